instr_decode_buffer: RTL

- Parametrised successor to the combinational instruction field splitter.
- Accepts 32-bit RV instruction words with PC over a valid/ready handshake and classifies the format from the opcode.
- Builds the sign-extended immediate and flags illegal encodings.
- Holds decoded entries in a DEPTH-entry FIFO between fetch and execute, with flush support for redirects.

---
 rtl/instr_decode_buffer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/instr_decode_buffer.sv
// RV32/64 instruction decoder feeding a small FIFO of decoded entries.
// Each entry holds the raw word, format, immediate, illegal flag and PC.
module instr_decode_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_funct3,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [6:0]       out_funct7,
  output logic [2:0]       out_fmt,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [XLEN-1:0]  out_pc,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [31:0]     instr;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              push;
  logic              pop;
  entry_t            dec_entry;
  logic [31:0]       imm32;
  entry_t            head;

  always_comb begin
    dec_entry         = '0;
    dec_entry.instr   = in_instr;
    dec_entry.pc      = in_pc;
    dec_entry.fmt     = FMT_ILL;
    dec_entry.illegal = 1'b1;
    imm32             = '0;
    if (in_instr[1:0] == 2'b11) begin
      dec_entry.illegal = 1'b0;
      case (in_instr[6:0])
        7'b0110011: dec_entry.fmt = FMT_R;
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
          dec_entry.fmt = FMT_I;
          imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end
        7'b0100011: begin
          dec_entry.fmt = FMT_S;
          imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        end
        7'b1100011: begin
          dec_entry.fmt = FMT_B;
          imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          dec_entry.fmt = FMT_U;
          imm32 = {in_instr[31:12], 12'b0};
        end
        7'b1101111: begin
          dec_entry.fmt = FMT_J;
          imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
        end
        default: begin
          dec_entry.fmt     = FMT_ILL;
          dec_entry.illegal = 1'b1;
        end
      endcase
    end
    // All immediates are 32-bit signed values, widened to XLEN here.
    dec_entry.imm = XLEN'($signed(imm32));
  end

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head = out_valid ? mem_q[rd_ptr_q] : '0;

  assign out_opcode  = head.instr[6:0];
  assign out_rd      = head.instr[11:7];
  assign out_funct3  = head.instr[14:12];
  assign out_rs1     = head.instr[19:15];
  assign out_rs2     = head.instr[24:20];
  assign out_funct7  = head.instr[31:25];
  assign out_fmt     = head.fmt;
  assign out_imm     = head.imm;
  assign out_illegal = head.illegal;
  assign out_pc      = head.pc;
  assign count       = count_q;

endmodule
